// File: rtl/program_counter_unit_pkg.sv
// Shared SAP-2 definitions: default bus widths and the program-counter
// load-sequencer state encoding. The controller imports this same package,
// so both blocks agree on widths and on what "low byte pending" means.
package program_counter_unit_pkg;

  localparam int unsigned SAP2_ADDR_W = 16;
  localparam int unsigned SAP2_DATA_W = 8;

  // A two-byte jump/return address arrives over the 8-bit bus as a low byte
  // (Lpcl) followed by a high byte (Lpcu). PC_LOW_HELD means the low byte
  // has been staged but not yet committed to the PC.
  typedef enum logic {
    PC_IDLE     = 1'b0,
    PC_LOW_HELD = 1'b1
  } pc_state_e;

endpackage : program_counter_unit_pkg

// File: rtl/program_counter_unit.sv
// program_counter_unit -- SAP-2 program counter.
//
// Holds the PC, increments it, loads it from two bus bytes (low byte staged
// first, high byte commits), and drives it onto the address bus or, one byte
// at a time, onto the data bus for CALL return-address saves.
//
// Ports
//   inCLK     clock, rising edge
//   inRST     asynchronous active-low reset
//   iCp       increment PC
//   iEp       drive PC onto oAddr
//   iLpcl     stage iBus as pending low byte
//   iLpcu     load upper byte from iBus; commits staged low byte if pending
//   iEpcl     drive PC low byte onto oData
//   iEpcu     drive PC high byte onto oData
//   iHLT      freeze PC, staging register and state
//   iBus      data bus input (address bytes)
//   oAddr     PC when iEp, else zero
//   oData     selected PC byte when iEpcl/iEpcu, else zero
//   oPC       current PC (always visible)
//   oPending  low byte staged, not yet committed
//   oErr      sticky illegal-control flag, cleared only by reset
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = SAP2_ADDR_W,
  parameter int unsigned DATA_W = SAP2_DATA_W
) (
  input  logic              inCLK,
  input  logic              inRST,
  input  logic              iCp,
  input  logic              iEp,
  input  logic              iLpcl,
  input  logic              iLpcu,
  input  logic              iEpcl,
  input  logic              iEpcu,
  input  logic              iHLT,
  input  logic [DATA_W-1:0] iBus,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData,
  output logic [ADDR_W-1:0] oPC,
  output logic              oPending,
  output logic              oErr
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic              err_q, err_d;

  logic load_clash;
  logic byte_clash;

  // Both load strobes at once cannot be ordered, so the cycle is dropped.
  // The clash is ignored while halted because halt masks all load strobes.
  assign load_clash = iLpcl && iLpcu && !iHLT;
  // Both byte enables at once would fight on a real bus; low byte wins.
  assign byte_clash = iEpcl && iEpcu;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the decode below can leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    stage_d = stage_q;
    err_d   = err_q || load_clash || byte_clash;

    if (!iHLT && !load_clash) begin
      if (iLpcu) begin
        // A load always beats a simultaneous increment.
        if (state_q == PC_LOW_HELD) begin
          pc_d    = {iBus, stage_q};
          state_d = PC_IDLE;
        end else begin
          pc_d = {iBus, pc_q[DATA_W-1:0]};
        end
      end else if (iLpcl) begin
        stage_d = iBus;
        state_d = PC_LOW_HELD;
      end else if (iCp) begin
        pc_d = pc_q + 1'b1;  // wraps modulo 2^ADDR_W
      end
    end
  end

  // NOTE: the staging byte is reset along with the PC so that a reset in the
  // middle of a two-byte load cannot leak a stale low byte into a later load.
  always_ff @(posedge inCLK or negedge inRST) begin
    if (!inRST) begin
      state_q <= PC_IDLE;
      pc_q    <= '0;
      stage_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      stage_q <= stage_d;
      err_q   <= err_d;
    end
  end

  assign oPC      = pc_q;
  assign oAddr    = iEp ? pc_q : '0;
  assign oData    = iEpcl ? pc_q[DATA_W-1:0] :
                    iEpcu ? pc_q[ADDR_W-1:DATA_W] : '0;
  assign oPending = (state_q == PC_LOW_HELD);
  assign oErr     = err_q;

endmodule : program_counter_unit
